axis_pipe_arbiter: RTL and testbench

AXIS_PIPE_ARBITER -- requirements
Module: axis_pipe_arbiter

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_rr_arbiter.sv | 28 ++
 rtl/axis_pipe_arbiter.sv | 141 ++++++++++++++
 tb/tb_axis_pipe_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream pipeline arbiter.
// Holds the FSM state encoding and a constant log2 function.
package axis_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Round-robin source picker: first requester after last_grant, circularly.
// Ports: req (request vector), last_grant -> next_grant index, any_req.
module axis_rr_arbiter #(
    parameter int NUM_SRC  = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic [NUM_SRC-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [ID_WIDTH-1:0] next_grant,
    output logic                any_req
);

    logic found;

    // Search offsets 1..NUM_SRC so last_grant itself is tried last.
    always_comb begin
        next_grant = '0;
        found      = 1'b0;
        any_req    = |req;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!found && req[(int'(last_grant) + k) % NUM_SRC]) begin
                found      = 1'b1;
                next_grant = ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/axis_pipe_arbiter.sv
// Packet-level round-robin arbiter feeding NUM_SRC streams into one
// fixed-latency external pipeline, with shadow valid/last/user/id pipes.
// Ports: axis_aclk/axis_aresetn; s_axis_* slaves (slotted vectors);
// m_axis_* master; pipe_cen/pipe_in_data/pipe_out_data to the pipeline.
module axis_pipe_arbiter
    import axis_pkg::*;
#(
    parameter  int NUM_SRC             = 2,
    parameter  int PIPE_DATA_IN_WIDTH  = 32,
    parameter  int PIPE_DATA_OUT_WIDTH = 32,
    parameter  int PIPE_QUAL_WIDTH     = 4,
    parameter  int PIPE_STAGES         = 8,
    localparam int ID_WIDTH = (clog2(NUM_SRC) > 1) ? clog2(NUM_SRC) : 1
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_aresetn,
    input  logic [NUM_SRC*PIPE_DATA_IN_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*PIPE_QUAL_WIDTH-1:0]    s_axis_tuser,
    input  logic [NUM_SRC-1:0]                    s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                    s_axis_tlast,
    output logic [NUM_SRC-1:0]                    s_axis_tready,
    output logic [PIPE_DATA_OUT_WIDTH-1:0]        m_axis_tdata,
    output logic [PIPE_QUAL_WIDTH-1:0]            m_axis_tuser,
    output logic [ID_WIDTH-1:0]                   m_axis_tid,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic                                  pipe_cen,
    output logic [PIPE_DATA_IN_WIDTH-1:0]         pipe_in_data,
    input  logic [PIPE_DATA_OUT_WIDTH-1:0]        pipe_out_data
);

    localparam int DW = PIPE_DATA_IN_WIDTH;
    localparam int QW = PIPE_QUAL_WIDTH;

    state_t                state;
    logic [ID_WIDTH-1:0]   grant;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   next_grant;
    logic                  any_req;

    logic                  busy;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DW-1:0]         sel_data;
    logic [QW-1:0]         sel_user;
    logic                  accept;

    logic [PIPE_STAGES-1:0] vld_sr;
    logic [PIPE_STAGES-1:0] lst_sr;
    logic [ID_WIDTH-1:0]    id_sr  [PIPE_STAGES];
    logic [QW-1:0]          usr_sr [PIPE_STAGES];

    axis_rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .next_grant (next_grant),
        .any_req    (any_req)
    );

    assign busy      = (state == ST_BUSY);
    assign sel_valid = s_axis_tvalid[grant];
    assign sel_last  = s_axis_tlast[grant];
    assign sel_data  = s_axis_tdata[grant*DW +: DW];
    assign sel_user  = s_axis_tuser[grant*QW +: QW];

    // Empty output slots never block; a held output beat freezes everything.
    assign pipe_cen     = ~m_axis_tvalid | m_axis_tready;
    assign accept       = busy & sel_valid & pipe_cen;
    assign pipe_in_data = busy ? sel_data : '0;

    always_comb begin
        s_axis_tready = '0;
        if (busy) begin
            s_axis_tready[grant] = pipe_cen;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(NUM_SRC - 1);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && sel_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            vld_sr <= '0;
            lst_sr <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                id_sr[i] <= '0;
            end
        end else if (pipe_cen) begin
            vld_sr[0] <= accept;
            lst_sr[0] <= accept & sel_last;
            id_sr[0]  <= grant;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                lst_sr[i] <= lst_sr[i-1];
                id_sr[i]  <= id_sr[i-1];
            end
        end
    end

    // Qualifiers travel with data, which is not reset either.
    always_ff @(posedge axis_aclk) begin
        if (pipe_cen) begin
            usr_sr[0] <= sel_user;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                usr_sr[i] <= usr_sr[i-1];
            end
        end
    end

    assign m_axis_tvalid = vld_sr[PIPE_STAGES-1];
    assign m_axis_tlast  = lst_sr[PIPE_STAGES-1];
    assign m_axis_tid    = id_sr[PIPE_STAGES-1];
    assign m_axis_tuser  = usr_sr[PIPE_STAGES-1];
    assign m_axis_tdata  = pipe_out_data;

endmodule

// File: tb/tb_axis_pipe_arbiter.sv
// Directed bench for axis_pipe_arbiter: a 2-source/4-stage instance
// and a 3-source/1-stage instance, each with a modelled data pipeline.
module tb_axis_pipe_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncheck = 0;
    int npass = 0;
    int nfail = 0;

    // ---------------- instance A: 2 sources, 4 stages ----------------
    logic        sv [2];
    logic [31:0] sd [2];
    logic [3:0]  su [2];
    logic        sl [2];
    logic [63:0] a_tdata;
    logic [7:0]  a_tuser;
    logic [1:0]  a_tvalid;
    logic [1:0]  a_tlast;
    logic [1:0]  a_tready;
    logic [31:0] a_mdata;
    logic [3:0]  a_muser;
    logic [0:0]  a_mtid;
    logic        a_mvalid;
    logic        a_mready;
    logic        a_mlast;
    logic        a_cen;
    logic [31:0] a_pin;
    logic [31:0] a_pout;
    logic [31:0] pa [4];

    assign a_tdata  = {sd[1], sd[0]};
    assign a_tuser  = {su[1], su[0]};
    assign a_tvalid = {sv[1], sv[0]};
    assign a_tlast  = {sl[1], sl[0]};

    axis_pipe_arbiter #(
        .NUM_SRC(2), .PIPE_DATA_IN_WIDTH(32), .PIPE_DATA_OUT_WIDTH(32),
        .PIPE_QUAL_WIDTH(4), .PIPE_STAGES(4)
    ) dut_a (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tdata(a_tdata), .s_axis_tuser(a_tuser),
        .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast),
        .s_axis_tready(a_tready),
        .m_axis_tdata(a_mdata), .m_axis_tuser(a_muser),
        .m_axis_tid(a_mtid), .m_axis_tvalid(a_mvalid),
        .m_axis_tready(a_mready), .m_axis_tlast(a_mlast),
        .pipe_cen(a_cen), .pipe_in_data(a_pin), .pipe_out_data(a_pout)
    );

    always @(posedge clk) begin
        if (a_cen) begin
            pa[0] <= a_pin;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pa[3] <= pa[2];
        end
    end
    assign a_pout = pa[3];

    // ---------------- instance B: 3 sources, 1 stage -----------------
    logic [95:0] b_tdata;
    logic [11:0] b_tuser;
    logic [2:0]  b_tvalid;
    logic [2:0]  b_tlast;
    logic [2:0]  b_tready;
    logic [31:0] b_mdata;
    logic [3:0]  b_muser;
    logic [1:0]  b_mtid;
    logic        b_mvalid;
    logic        b_mready;
    logic        b_mlast;
    logic        b_cen;
    logic [31:0] b_pin;
    logic [31:0] b_pout;

    assign b_tdata  = {32'hA2, 32'hA1, 32'hA0};
    assign b_tuser  = {4'h3, 4'h2, 4'h1};
    assign b_tlast  = 3'b111;
    assign b_mready = 1'b1;

    axis_pipe_arbiter #(
        .NUM_SRC(3), .PIPE_DATA_IN_WIDTH(32), .PIPE_DATA_OUT_WIDTH(32),
        .PIPE_QUAL_WIDTH(4), .PIPE_STAGES(1)
    ) dut_b (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tdata(b_tdata), .s_axis_tuser(b_tuser),
        .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast),
        .s_axis_tready(b_tready),
        .m_axis_tdata(b_mdata), .m_axis_tuser(b_muser),
        .m_axis_tid(b_mtid), .m_axis_tvalid(b_mvalid),
        .m_axis_tready(b_mready), .m_axis_tlast(b_mlast),
        .pipe_cen(b_cen), .pipe_in_data(b_pin), .pipe_out_data(b_pout)
    );

    always @(posedge clk) begin
        if (b_cen) b_pout <= b_pin;
    end

    // ---------------- beat logs ----------------
    typedef struct {
        int          src;
        logic [31:0] d;
        logic        l;
        logic [3:0]  u;
        int          cyc;
        logic [31:0] p;
    } beat_t;

    beat_t accq[$];
    beat_t outq[$];
    beat_t outb[$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sv[i] && a_tready[i])
                accq.push_back('{i, sd[i], sl[i], su[i], cyc, a_pin});
        end
        if (a_mvalid && a_mready)
            outq.push_back('{int'(a_mtid), a_mdata, a_mlast, a_muser, cyc, 32'h0});
        if (b_mvalid)
            outb.push_back('{int'(b_mtid), b_mdata, b_mlast, b_muser, cyc, 32'h0});
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_pkt(input int src, input int n, input logic [31:0] base,
                            input logic [3:0] usr, input int gap);
        for (int i = 0; i < n; i++) begin
            bit ok;
            ok = 1'b0;
            sv[src] = 1'b1;
            sd[src] = base + 32'(i);
            sl[src] = (i == n - 1);
            su[src] = usr;
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = a_tready[src];
            end
            if (!ok) begin
                ncheck++;
                nfail++;
                $error("FAIL timeout_src%0d: observed no tready expected tready", src);
            end
            tick();
            if (i == 0 && gap > 0) begin
                sv[src] = 1'b0;
                repeat (gap) tick();
            end
        end
        sv[src] = 1'b0;
        sl[src] = 1'b0;
    endtask

    int c0;
    logic [31:0] e2_d [8] = '{32'h20, 32'h21, 32'h30, 32'h31,
                              32'h22, 32'h23, 32'h32, 32'h33};
    int          e2_t [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        #500000;
        $display("FAIL watchdog: observed hang expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            sv[i] = 0; sd[i] = 0; su[i] = 0; sl[i] = 0;
        end
        a_mready = 1'b1;
        b_tvalid = 3'b000;
        #2;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_tready", a_tready, 2'b00);
        chk("rst_mvalid", a_mvalid, 1'b0);
        chk("rst_mlast", a_mlast, 1'b0);
        chk("rst_mtid", a_mtid, 1'b0);
        chk("rst_cen", a_cen, 1'b1);
        chk("rst_pin", a_pin, 32'h0);
        chk("rst_b_mvalid", b_mvalid, 1'b0);
        tick();

        // single 3-beat packet from src0
        accq.delete(); outq.delete();
        c0 = cyc;
        send_pkt(0, 3, 32'h11, 4'h3, 0);
        repeat (8) tick();
        chk("t1_nacc", accq.size(), 3);
        chk("t1_nout", outq.size(), 3);
        if (accq.size() == 3 && outq.size() == 3) begin
            chk("t1_acc_cyc", accq[0].cyc, c0 + 1);
            chk("t1_latency", outq[0].cyc, accq[0].cyc + 4);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("t1_pin%0d", i), accq[i].p, 32'h11 + i);
                chk($sformatf("t1_d%0d", i), outq[i].d, 32'h11 + i);
                chk($sformatf("t1_tid%0d", i), outq[i].src, 0);
                chk($sformatf("t1_last%0d", i), outq[i].l, i == 2);
                chk($sformatf("t1_user%0d", i), outq[i].u, 4'h3);
            end
        end

        // two sources, back-to-back 2-beat packets
        do_reset();
        accq.delete(); outq.delete();
        fork
            begin
                send_pkt(0, 2, 32'h20, 4'h5, 0);
                send_pkt(0, 2, 32'h22, 4'h5, 0);
            end
            begin
                send_pkt(1, 2, 32'h30, 4'h9, 0);
                send_pkt(1, 2, 32'h32, 4'h9, 0);
            end
        join
        repeat (8) tick();
        chk("t2_nout", outq.size(), 8);
        if (outq.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t2_d%0d", i), outq[i].d, e2_d[i]);
                chk($sformatf("t2_tid%0d", i), outq[i].src, e2_t[i]);
                chk($sformatf("t2_user%0d", i), outq[i].u, e2_t[i] == 0 ? 4'h5 : 4'h9);
            end
            chk("t2_gap", outq[2].cyc, outq[1].cyc + 2);
            chk("t2_gap2", outq[4].cyc, outq[3].cyc + 2);
        end

        // output stall for 5 cycles mid-stream
        accq.delete(); outq.delete();
        fork
            send_pkt(0, 6, 32'h40, 4'h7, 0);
            begin
                repeat (6) tick();
                a_mready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("t3_mvalid%0d", i), a_mvalid, 1'b1);
                    chk($sformatf("t3_mdata%0d", i), a_mdata, 32'h41);
                    chk($sformatf("t3_tready%0d", i), a_tready, 2'b00);
                    chk($sformatf("t3_cen%0d", i), a_cen, 1'b0);
                    tick();
                end
                a_mready = 1'b1;
            end
        join
        repeat (10) tick();
        chk("t3_nout", outq.size(), 6);
        if (outq.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t3_d%0d", i), outq[i].d, 32'h40 + i);
                chk($sformatf("t3_last%0d", i), outq[i].l, i == 5);
            end
        end

        // src1 bubbles mid-packet while src0 waits
        accq.delete(); outq.delete();
        c0 = cyc;
        fork
            send_pkt(1, 3, 32'h50, 4'h2, 3);
            send_pkt(0, 1, 32'h60, 4'h4, 0);
        join
        repeat (8) tick();
        chk("t4_nout", outq.size(), 4);
        chk("t4_nacc", accq.size(), 4);
        if (outq.size() == 4 && accq.size() == 4) begin
            chk("t4_d0", outq[0].d, 32'h50);
            chk("t4_d1", outq[1].d, 32'h51);
            chk("t4_d2", outq[2].d, 32'h52);
            chk("t4_d3", outq[3].d, 32'h60);
            chk("t4_tid2", outq[2].src, 1);
            chk("t4_tid3", outq[3].src, 0);
            chk("t4_src0_acc", accq[3].cyc, c0 + 8);
        end

        // reset with beats in flight
        sv[1] = 1'b1; sd[1] = 32'h70; sl[1] = 1'b0; su[1] = 4'h1;
        tick();
        tick();
        sd[1] = 32'h71;
        tick();
        sd[1] = 32'h72;
        tick();
        sv[1] = 1'b0;
        tick();
        chk("t5_pre_mvalid", a_mvalid, 1'b1);
        chk("t5_pre_mdata", a_mdata, 32'h70);
        rst_n = 1'b0;
        #1;
        chk("t5_mvalid", a_mvalid, 1'b0);
        chk("t5_mlast", a_mlast, 1'b0);
        chk("t5_mtid", a_mtid, 1'b0);
        chk("t5_tready", a_tready, 2'b00);
        chk("t5_cen", a_cen, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        accq.delete(); outq.delete();
        fork
            send_pkt(1, 1, 32'h90, 4'h6, 0);
            send_pkt(0, 1, 32'h80, 4'h8, 0);
        join
        repeat (8) tick();
        chk("t5_nout", outq.size(), 2);
        if (outq.size() == 2) begin
            chk("t5_first_tid", outq[0].src, 0);
            chk("t5_first_d", outq[0].d, 32'h80);
            chk("t5_second_tid", outq[1].src, 1);
            chk("t5_second_d", outq[1].d, 32'h90);
        end

        // 3-source, 1-stage instance: full round robin
        outb.delete();
        b_tvalid = 3'b111;
        repeat (24) tick();
        b_tvalid = 3'b000;
        repeat (4) tick();
        chk("tb_nout_ge6", outb.size() >= 6, 1'b1);
        if (outb.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("tb_tid%0d", i), outb[i].src, i % 3);
                chk($sformatf("tb_d%0d", i), outb[i].d, 32'hA0 + (i % 3));
                chk($sformatf("tb_user%0d", i), outb[i].u, 1 + (i % 3));
                chk($sformatf("tb_last%0d", i), outb[i].l, 1'b1);
            end
            chk("tb_spacing", outb[1].cyc, outb[0].cyc + 2);
        end

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
